// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding
package uart_pkg;
    localparam int CLK_HZ     = 100_000_000;
    localparam int BAUD       = 115200;
    localparam int OS_RATE    = 16;
    localparam int FIFO_DEPTH = 16;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO with occupancy count
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];
    // pointers wrap naturally; count is one bit wider so a full FIFO is representable
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, do_push};
            rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, do_pop};
            count  <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end
    // storage needs no reset; entries are only read once written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampled, feeding an FWFT FIFO with sticky error flags
module uart_rx #(
    parameter int OS_DIV     = uart_pkg::CLK_HZ / (uart_pkg::BAUD * uart_pkg::OS_RATE),
    parameter int FIFO_DEPTH = uart_pkg::FIFO_DEPTH,
    parameter int PTR_W      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx_in,
    input  logic           rd_en,
    output logic [7:0]     rd_data,
    output logic           rx_avail,
    output logic [PTR_W:0] rx_count,
    output logic           overrun,
    output logic           frame_err,
    input  logic           clr_err
);
    import uart_pkg::*;
    localparam int TW = OS_DIV > 1 ? $clog2(OS_DIV) : 1;
    localparam logic [3:0] SC_MID = 4'(OS_RATE / 2 - 1);
    localparam logic [3:0] SC_END = 4'(OS_RATE - 1);
    logic rx_m, rx_s, os_tick, stop_pt, push, set_ovr, set_fe, full, empty;
    logic [TW-1:0] tcnt;
    rx_state_t state, state_n;
    logic [3:0] sc, sc_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n;
    // two-flop synchroniser; idles high so reset looks like an idle line
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end
    assign os_tick = tcnt == TW'(OS_DIV - 1);
    // free-running oversample divider, never realigned to the start edge
    always_ff @(posedge clk) begin
        tcnt <= (reset || os_tick) ? '0 : tcnt + 1'b1;
    end
    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            sc      <= sc_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
        end
    end
    // next-state logic, advancing only on oversample ticks
    always_comb begin
        state_n = state;
        sc_n    = sc;
        bit_n   = bit_idx;
        shreg_n = shreg;
        if (os_tick) begin
            case (state)
                IDLE: begin
                    sc_n = '0;
                    if (!rx_s) state_n = START;
                end
                START: begin
                    sc_n = sc + 1'b1;
                    if (sc == SC_MID) begin
                        state_n = rx_s ? IDLE : DATA;
                        sc_n    = '0;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    sc_n = sc + 1'b1;
                    if (sc == SC_END) begin
                        shreg_n = {rx_s, shreg[7:1]};
                        bit_n   = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state_n = STOP;
                    end
                end
                STOP: begin
                    sc_n = sc + 1'b1;
                    if (sc == SC_END) state_n = rx_s ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: if (rx_s) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    assign stop_pt = os_tick && state == STOP && sc == SC_END;
    // stop-bit decision: a pop in the same cycle frees a slot in a full FIFO
    always_comb begin
        push    = stop_pt && rx_s && (!full || rd_en);
        set_ovr = stop_pt && rx_s && full && !rd_en;
        set_fe  = stop_pt && !rx_s;
    end
    // sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= set_ovr || (overrun && !clr_err);
            frame_err <= set_fe || (frame_err && !clr_err);
        end
    end
    uart_rx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(shreg),
        .pop      (rd_en),
        .pop_data (rd_data),
        .full     (full),
        .empty    (empty),
        .count    (rx_count)
    );
    assign rx_avail = !empty;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames against uart_rx with OS_DIV=4 (64 clocks per bit)
module tb_uart_rx;
    logic clk = 1'b0, reset = 1'b1, rx_in = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] rd_data;
    logic rx_avail, overrun, frame_err;
    logic [4:0] rx_count;
    logic [1:0] phase;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    uart_rx #(.OS_DIV(4), .FIFO_DEPTH(16), .PTR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rx_avail (rx_avail),
        .rx_count (rx_count),
        .overrun  (overrun),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    // oversample phase since reset, so every frame starts at a known tick offset
    always_ff @(posedge clk) phase <= reset ? 2'd0 : phase + 2'd1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic av, input logic [4:0] cnt,
                              input logic ovr, input logic fe);
        @(negedge clk);
        chk({tag, "_avail"}, 16'(rx_avail), 16'(av));
        chk({tag, "_count"}, 16'(rx_count), 16'(cnt));
        chk({tag, "_overrun"}, 16'(overrun), 16'(ovr));
        chk({tag, "_frame_err"}, 16'(frame_err), 16'(fe));
    endtask

    // start bit leaves right after a posedge that sets phase=1; stop push lands 611 clocks later
    task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic pop_stop);
        do begin
            @(posedge clk);
            #1;
        end while (phase != 2'd1);
        rx_in = 1'b0;
        repeat (64) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (64) @(posedge clk);
            #1;
        end
        rx_in = stop_b;
        if (pop_stop) begin
            repeat (34) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
            repeat (29) @(posedge clk);
            #1;
        end else begin
            repeat (64) @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        @(negedge clk);
        chk("pop_avail", 16'(rx_avail), 16'd1);
        chk("pop_data", 16'(rd_data), 16'(exp));
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_status("reset", 1'b0, 5'd0, 1'b0, 1'b0);

        send_byte(8'hA5, 1'b1, 1'b0);
        chk_status("single", 1'b1, 5'd1, 1'b0, 1'b0);
        pop_chk(8'hA5);
        chk_status("single_popped", 1'b0, 5'd0, 1'b0, 1'b0);

        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        chk_status("pop_empty", 1'b0, 5'd0, 1'b0, 1'b0);

        rx_in = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (100) @(posedge clk);
        chk_status("glitch", 1'b0, 5'd0, 1'b0, 1'b0);

        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (200) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (64) @(posedge clk);
        chk_status("frame_bad", 1'b0, 5'd0, 1'b0, 1'b1);
        send_byte(8'h11, 1'b1, 1'b0);
        chk_status("frame_next", 1'b1, 5'd1, 1'b0, 1'b1);
        pulse_clr();
        chk_status("frame_clr", 1'b1, 5'd1, 1'b0, 1'b0);
        pop_chk(8'h11);
        chk_status("frame_drained", 1'b0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 1'b0);
        chk_status("full", 1'b1, 5'd16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) pop_chk(8'(i));
        chk_status("full_drained", 1'b0, 5'd0, 1'b1, 1'b0);
        pulse_clr();
        chk_status("ovr_clr", 1'b0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) send_byte(8'h60 + 8'(i), 1'b1, 1'b0);
        chk_status("refill", 1'b1, 5'd16, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b1);
        chk_status("simul", 1'b1, 5'd16, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) pop_chk(8'h60 + 8'(i));
        pop_chk(8'h77);
        chk_status("simul_drained", 1'b0, 5'd0, 1'b0, 1'b0);

        send_byte(8'h33, 1'b1, 1'b0);
        chk_status("pre_reset", 1'b1, 5'd1, 1'b0, 1'b0);
        do begin
            @(posedge clk);
            #1;
        end while (phase != 2'd1);
        rx_in = 1'b0;
        repeat (296) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_status("mid_reset", 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (22) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (320) @(posedge clk);
        chk_status("post_reset_idle", 1'b0, 5'd0, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        chk_status("post_reset", 1'b1, 5'd1, 1'b0, 1'b0);
        pop_chk(8'h5A);
        chk_status("post_reset_drained", 1'b0, 5'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
